// File: rtl/fp_coef_streamer_if.sv
// Stream port from the coefficient streamer to the FIR MAC: one tap per valid/ready beat.
interface fp_coef_streamer_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_tap;
  logic          out_last;

  modport master (output out_valid, out_data, out_tap, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_tap, out_last, output out_ready);
endinterface

// File: rtl/fp_coef_streamer.sv
// Banked FP coefficient store that streams one TAPS-long set per start, with optional
// mirrored (symmetric) addressing and sign inversion.
module fp_coef_streamer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned TAPS  = 64,
  parameter int unsigned BANKS = 2,
  parameter int unsigned SYM   = 1,
  localparam int unsigned AW   = $clog2(TAPS),
  localparam int unsigned BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  input  logic          start,
  input  logic [BW-1:0] start_bank,
  input  logic          start_neg,
  output logic          busy,
  fp_coef_streamer_if.master strm
);

  localparam int unsigned D   = (SYM != 0) ? TAPS / 2 : TAPS;
  localparam int unsigned DAW = (D > 1) ? $clog2(D) : 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [DW-1:0] mem [BANKS][D];

  logic [0:0]    state_q, state_d;
  logic [BW-1:0] bank_q, bank_d;
  logic          neg_q, neg_d;
  logic [AW-1:0] tap_q, tap_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          wr_err_q;

  logic          start_ok, wr_ok;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_tap, rd_entry;
  logic [DAW-1:0] rd_idx;
  logic [DW-1:0] rd_word, sign_flip;
  logic          neg_sel;

  assign busy     = (state_q == StStream);
  assign start_ok = (state_q == StIdle) && start && (32'(start_bank) < BANKS);

  // The bank being started is already active at this edge, so a same-cycle write to it is refused.
  assign wr_ok = !rst && wr_en && (32'(wr_addr) < D) && (32'(wr_bank) < BANKS) &&
                 !(busy && (wr_bank == bank_q)) &&
                 !(start_ok && (wr_bank == start_bank));

  // Read port looks one tap ahead so the output registers carry the word being presented.
  always_comb begin
    if (state_q == StIdle) begin
      rd_bank = start_bank;
      rd_tap  = '0;
      neg_sel = start_neg;
    end else begin
      rd_bank = bank_q;
      rd_tap  = tap_q + AW'(1);
      neg_sel = neg_q;
    end
    if ((SYM != 0) && (rd_tap >= AW'(TAPS / 2))) begin
      rd_entry = AW'(TAPS - 1) - rd_tap;
    end else begin
      rd_entry = rd_tap;
    end
    rd_idx    = DAW'(rd_entry);
    rd_word   = mem[rd_bank][rd_idx];
    sign_flip = {neg_sel, {(DW-1){1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    neg_d   = neg_q;
    tap_d   = tap_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StStream;
          bank_d  = start_bank;
          neg_d   = start_neg;
          tap_d   = '0;
          data_d  = rd_word ^ sign_flip;
          last_d  = 1'b0;
        end
      end
      StStream: begin
        if (strm.out_ready) begin
          if (last_q) begin
            state_d = StIdle;
            tap_d   = '0;
            last_d  = 1'b0;
          end else begin
            tap_d  = rd_tap;
            data_d = rd_word ^ sign_flip;
            last_d = (32'(rd_tap) == TAPS - 1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      bank_q   <= '0;
      neg_q    <= 1'b0;
      tap_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      neg_q    <= neg_d;
      tap_q    <= tap_d;
      data_q   <= data_d;
      last_q   <= last_d;
      wr_err_q <= wr_en && !wr_ok;
    end
  end

  // Storage is deliberately outside the reset domain: coefficients survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_bank][DAW'(wr_addr)] <= wr_data;
    end
  end

  assign wr_err         = wr_err_q;
  assign strm.out_valid = (state_q == StStream);
  assign strm.out_data  = data_q;
  assign strm.out_tap   = tap_q;
  assign strm.out_last  = last_q;

endmodule

// File: tb/tb_fp_coef_streamer.sv
// Bench for fp_coef_streamer: default symmetric config plus a small linear config,
// checked against a plain coefficient-array model.
module tb_fp_coef_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Config A: DW=16 TAPS=64 BANKS=2 SYM=1
  logic        a_rst = 1'b1, a_wr_en = 1'b0, a_wr_err, a_start = 1'b0, a_start_neg = 1'b0;
  logic        a_busy, a_wr_bank = 1'b0, a_start_bank = 1'b0;
  logic [5:0]  a_wr_addr = '0;
  logic [15:0] a_wr_data = '0;
  fp_coef_streamer_if #(.DW(16), .AW(6)) ifa ();

  fp_coef_streamer dut_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_err(a_wr_err), .start(a_start), .start_bank(a_start_bank),
    .start_neg(a_start_neg), .busy(a_busy), .strm(ifa)
  );

  // Config B: DW=16 TAPS=8 BANKS=4 SYM=0
  logic        b_rst = 1'b1, b_wr_en = 1'b0, b_wr_err, b_start = 1'b0, b_start_neg = 1'b0;
  logic        b_busy;
  logic [1:0]  b_wr_bank = '0, b_start_bank = '0;
  logic [2:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  fp_coef_streamer_if #(.DW(16), .AW(3)) ifb ();

  fp_coef_streamer #(.DW(16), .TAPS(8), .BANKS(4), .SYM(0)) dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_err(b_wr_err), .start(b_start), .start_bank(b_start_bank),
    .start_neg(b_start_neg), .busy(b_busy), .strm(ifb)
  );

  logic [15:0] ma [2][32];
  logic [15:0] cap_data [64];
  logic        cap_last [64];

  typedef struct {
    string       name;
    int          tap;
    logic        neg;
    logic [15:0] data;
    logic        last;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_a(input int b, input logic neg, input int k);
    int e;
    e = (k < 32) ? k : 63 - k;
    return ma[b][e] ^ (neg ? 16'h8000 : 16'h0000);
  endfunction

  task automatic a_write(input int b, input int addr, input logic [15:0] d, input logic exp_err,
                         input string name);
    a_wr_en = 1'b1; a_wr_bank = 1'(b); a_wr_addr = 6'(addr); a_wr_data = d;
    @(negedge clk);
    a_wr_en = 1'b0;
    check(name, 32'(a_wr_err), 32'(exp_err));
    if (!exp_err) ma[b][addr] = d;
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready. rst_at >= 0 aborts at that tap.
  task automatic a_stream(input int b, input logic neg, input int mode, input int rst_at,
                          input logic wr_same);
    int k, cyc;
    logic r;
    logic [3:0] pat;
    pat = 4'b1001; k = 0; cyc = 0;
    a_start = 1'b1; a_start_bank = 1'(b); a_start_neg = neg;
    if (wr_same) begin
      a_wr_en = 1'b1; a_wr_bank = 1'(b); a_wr_addr = '0; a_wr_data = 16'h7777;
    end
    @(negedge clk);
    a_start = 1'b0; a_wr_en = 1'b0;
    if (wr_same) check("wr_same_cycle_as_start", 32'(a_wr_err), 32'd1);
    check("start_busy", 32'(a_busy), 32'd1);
    check("start_valid", 32'(ifa.out_valid), 32'd1);
    while (k < 64 && cyc < 2000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      ifa.out_ready = r;
      if (k == rst_at) begin
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        check("rst_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        return;
      end
      check("beat_valid", 32'(ifa.out_valid), 32'd1);
      check("beat_tap", 32'(ifa.out_tap), 32'(k));
      check("beat_data", 32'(ifa.out_data), 32'(exp_a(b, neg, k)));
      check("beat_last", 32'(ifa.out_last), 32'(k == 63));
      cap_data[k] = ifa.out_data;
      cap_last[k] = ifa.out_last;
      if (r) k++;
      cyc++;
      @(negedge clk);
    end
    check("stream_tap_count", 32'(k), 32'd64);
    check("end_valid", 32'(ifa.out_valid), 32'd0);
    check("end_busy", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"mirror_tap0",  0,  1'b0, 16'h1000, 1'b0};
    vt[1] = '{"mirror_tap31", 31, 1'b0, 16'h101F, 1'b0};
    vt[2] = '{"mirror_tap32", 32, 1'b0, 16'h101F, 1'b0};
    vt[3] = '{"mirror_tap63", 63, 1'b0, 16'h1000, 1'b1};
    vt[4] = '{"neg_tap0",     0,  1'b1, 16'h9000, 1'b0};
    vt[5] = '{"neg_tap40",    40, 1'b1, 16'h9017, 1'b0};

    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_last", 32'(ifa.out_last), 32'd0);
    check("rst_wr_err", 32'(a_wr_err), 32'd0);
    check("rst_out_data", 32'(ifa.out_data), 32'd0);
    check("rst_out_tap", 32'(ifa.out_tap), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    for (int i = 0; i < 32; i++) a_write(0, i, 16'h1000 + 16'(i), 1'b0, "fill_bank0");
    for (int i = 0; i < 32; i++) a_write(1, i, 16'h2000 + 16'(i), 1'b0, "fill_bank1");

    // Mirrored readout, then negation, each checked against the vector table.
    for (int pass = 0; pass < 2; pass++) begin
      a_stream(0, 1'(pass), 0, -1, 1'b0);
      for (int v = 0; v < 6; v++) begin
        if (vt[v].neg == 1'(pass)) begin
          check(vt[v].name, 32'(cap_data[vt[v].tap]), 32'(vt[v].data));
          check({vt[v].name, "_last"}, 32'(cap_last[vt[v].tap]), 32'(vt[v].last));
        end
      end
    end

    a_stream(0, 1'b0, 1, -1, 1'b0);

    // Write protection and range checks during a bank 0 stream.
    fork
      a_stream(0, 1'b0, 0, -1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        a_write(0, 5, 16'hDEAD, 1'b1, "wr_active_bank");
        a_write(1, 5, 16'h3C00, 1'b0, "wr_other_bank");
        a_write(1, 32, 16'h1234, 1'b1, "wr_addr_range");
        @(negedge clk);
        check("wr_err_pulse_width", 32'(a_wr_err), 32'd0);
      end
    join
    a_stream(0, 1'b0, 0, -1, 1'b0);
    check("bank0_old_value_tap5", 32'(cap_data[5]), 32'h1005);
    a_stream(1, 1'b0, 0, -1, 1'b0);
    check("bank1_new_tap5", 32'(cap_data[5]), 32'h3C00);
    check("bank1_new_tap58", 32'(cap_data[58]), 32'h3C00);

    // Reset mid-stream, then a clean stream with contents intact.
    a_stream(0, 1'b0, 0, 10, 1'b0);
    a_stream(0, 1'b0, 0, -1, 1'b0);

    // Start while busy must be ignored and not queued.
    fork
      a_stream(0, 1'b0, 0, -1, 1'b0);
      begin
        repeat (5) @(negedge clk);
        a_start = 1'b1; a_start_bank = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
      end
    join
    @(negedge clk);
    check("no_queued_start", 32'(a_busy), 32'd0);

    a_stream(1, 1'b0, 0, -1, 1'b1);

    // Random contents, sign and backpressure.
    for (int it = 0; it < 4; it++) begin
      int rb;
      rb = $urandom_range(0, 1);
      for (int i = 0; i < 32; i++) a_write(rb, i, 16'($urandom), 1'b0, "rand_fill");
      a_stream(rb, 1'($urandom_range(0, 1)), 2, -1, 1'b0);
    end

    // Config B: linear readout from bank 3, bank 2 holds distinct data.
    for (int i = 0; i < 8; i++) begin
      for (int bk = 2; bk < 4; bk++) begin
        b_wr_en = 1'b1; b_wr_bank = 2'(bk); b_wr_addr = 3'(i);
        b_wr_data = (bk == 3) ? 16'(i) : 16'hA000 + 16'(i);
        @(negedge clk);
        b_wr_en = 1'b0;
        check("b_fill", 32'(b_wr_err), 32'd0);
      end
    end
    b_start = 1'b1; b_start_bank = 2'd3;
    ifb.out_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int k, cyc;
      k = 0; cyc = 0;
      while (k < 8 && cyc < 100) begin
        check("b_valid", 32'(ifb.out_valid), 32'd1);
        check("b_tap", 32'(ifb.out_tap), 32'(k));
        check("b_data", 32'(ifb.out_data), 32'(k));
        check("b_last", 32'(ifb.out_last), 32'(k == 7));
        if (ifb.out_valid) k++;
        cyc++;
        @(negedge clk);
      end
      check("b_tap_count", 32'(k), 32'd8);
    end
    check("b_end_valid", 32'(ifb.out_valid), 32'd0);
    check("b_end_busy", 32'(b_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
